// File: rtl/fetch_execute_controller_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer:
// state encoding, instruction field layout and opcode constants.
package fetch_execute_controller_pkg;

  localparam int unsigned INSTR_W = 6;
  localparam int unsigned OPC_MSB = 5;
  localparam int unsigned OPC_LSB = 2;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_ALU_MAX = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_STORE   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_HALT    = OPC_W'(15);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_execute_controller.sv
// Instruction sequencer: fetches 6-bit words from program memory, latches them
// into the IR and issues one-cycle decode/execute strobes; fetch timeout halts.
module fetch_execute_controller
  import fetch_execute_controller_pkg::*;
#(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  output logic               prog_rd,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               prog_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               ir_valid,
  output logic               aku_load,
  output logic               reg_write,
  output logic               busy,
  output logic               halted,
  output logic               fetch_err
);

  localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_prog_rd;
  logic                 r_ir_valid;
  logic                 r_aku_load;
  logic                 r_reg_write;
  logic                 r_busy;
  logic                 r_halted;
  logic                 r_fetch_err;

  logic [OPC_W-1:0]     w_opc;
  logic                 w_cnt_hit;
  logic                 w_ir_load;
  logic                 w_pc_inc;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_err_set;
  logic                 w_prog_rd_nxt;
  logic                 w_ir_valid_nxt;
  logic                 w_aku_load_nxt;
  logic                 w_reg_write_nxt;
  logic                 w_busy_nxt;
  logic                 w_halted_nxt;

  assign w_opc     = opcode_of(r_ir);
  assign w_cnt_hit = (r_cnt == CNT_W'(FETCH_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; output strobes are derived from the next state so they
  // come out of flops aligned with the state they belong to.
  always_comb begin
    w_state_next    = r_state;
    w_ir_load       = 1'b0;
    w_pc_inc        = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_err_set       = 1'b0;
    w_prog_rd_nxt   = 1'b0;
    w_ir_valid_nxt  = 1'b0;
    w_aku_load_nxt  = 1'b0;
    w_reg_write_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_halted_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run && !halt_req) begin
          w_state_next = ST_FETCH;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (prog_valid) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_DECODE;
        end else begin
          w_cnt_inc = 1'b1;
          if (w_cnt_hit) begin
            w_state_next = ST_HALT;
            w_err_set    = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        w_state_next = (w_opc == OP_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_pc_inc = 1'b1;
        if (halt_req || !run) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_FETCH;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_HALT: begin
        if (!run) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_prog_rd_nxt   = (w_state_next == ST_FETCH);
    w_ir_valid_nxt  = (w_state_next == ST_DECODE);
    w_aku_load_nxt  = (w_state_next == ST_EXECUTE) && (w_opc <= OP_ALU_MAX);
    w_reg_write_nxt = (w_state_next == ST_EXECUTE) && (w_opc == OP_STORE);
    w_busy_nxt      = (w_state_next == ST_FETCH) || (w_state_next == ST_DECODE) ||
                      (w_state_next == ST_EXECUTE);
    w_halted_nxt    = (w_state_next == ST_HALT);
  end

  // Datapath: program counter, instruction register, fetch wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pc_inc) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      if (w_ir_load) begin
        r_ir <= prog_data;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered status outputs and strobes; fetch_err is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prog_rd   <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_aku_load  <= 1'b0;
      r_reg_write <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_prog_rd   <= w_prog_rd_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
      r_aku_load  <= w_aku_load_nxt;
      r_reg_write <= w_reg_write_nxt;
      r_busy      <= w_busy_nxt;
      r_halted    <= w_halted_nxt;
      r_fetch_err <= r_fetch_err | w_err_set;
    end
  end

  assign prog_rd     = r_prog_rd;
  assign prog_addr   = r_pc;
  assign instruction = r_ir;
  assign ir_valid    = r_ir_valid;
  assign aku_load    = r_aku_load;
  assign reg_write   = r_reg_write;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_execute_controller.sv
// Scoreboard bench for fetch_execute_controller: stimulus queues expected
// events, a negedge monitor pops and compares whenever the DUT emits one.
module tb_fetch_execute_controller;

  localparam int unsigned ADDR_W = 8;

  localparam int K_DEC   = 0;
  localparam int K_ALU   = 1;
  localparam int K_STORE = 2;
  localparam int K_HALT  = 3;
  localparam int K_IDLE  = 4;

  typedef struct {
    int kind;
    int val;
    int err;
    int cyc;
  } ev_t;

  logic              clk;
  logic              rst;
  logic              run;
  logic              halt_req;
  logic              prog_rd;
  logic [ADDR_W-1:0] prog_addr;
  logic [5:0]        prog_data;
  logic              prog_valid;
  logic [5:0]        instruction;
  logic              ir_valid;
  logic              aku_load;
  logic              reg_write;
  logic              busy;
  logic              halted;
  logic              fetch_err;

  logic [5:0] rom [256];
  logic       en_valid;
  int         dly;
  int         fcnt;
  int         cyc;
  int         t0;
  int         n_cmp;
  int         n_bad;
  ev_t        sb[$];
  logic       prev_busy;
  logic       prev_halted;

  fetch_execute_controller #(.ADDR_W(ADDR_W), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_valid(prog_valid), .instruction(instruction), .ir_valid(ir_valid),
    .aku_load(aku_load), .reg_write(reg_write), .busy(busy),
    .halted(halted), .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory model with a configurable acknowledge delay per fetch
  assign prog_data  = rom[prog_addr];
  assign prog_valid = prog_rd & en_valid & (fcnt >= dly);

  always @(posedge clk or posedge rst) begin
    if (rst)                      fcnt <= 0;
    else if (prog_rd && !prog_valid) fcnt <= fcnt + 1;
    else                          fcnt <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ex(input int k, input int v, input int e, input int c);
    ev_t ev;
    ev.kind = k; ev.val = v; ev.err = e; ev.cyc = c;
    sb.push_back(ev);
  endtask

  task automatic take(input int k, input int v, input int e);
    ev_t ev;
    int  rc;
    rc = cyc - t0;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h cyc=%0d, expected no event", k, v, rc);
    end else begin
      ev = sb.pop_front();
      if (ev.kind != k || ev.val != v || (ev.err >= 0 && ev.err != e) ||
          (ev.cyc >= 0 && ev.cyc != rc)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d val=%0h err=%0d cyc=%0d, expected kind=%0d val=%0h err=%0d cyc=%0d",
                 k, v, e, rc, ev.kind, ev.val, ev.err, ev.cyc);
      end
    end
  endtask

  // Monitor: turns output strobes and state edges into events for the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_busy   <= 1'b0;
      prev_halted <= 1'b0;
    end else begin
      if (ir_valid)                  take(K_DEC, int'(instruction), -1);
      if (aku_load)                  take(K_ALU, int'(prog_addr), -1);
      if (reg_write)                 take(K_STORE, int'(prog_addr), -1);
      if (halted && !prev_halted)    take(K_HALT, int'(prog_addr), int'(fetch_err));
      if (!busy && !halted && (prev_busy || prev_halted)) take(K_IDLE, int'(prog_addr), -1);
      prev_busy   <= busy;
      prev_halted <= halted;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prog_rd"},     32'(prog_rd), 0);
    chk({tag, "_prog_addr"},   32'(prog_addr), 0);
    chk({tag, "_instruction"}, 32'(instruction), 0);
    chk({tag, "_ir_valid"},    32'(ir_valid), 0);
    chk({tag, "_aku_load"},    32'(aku_load), 0);
    chk({tag, "_reg_write"},   32'(reg_write), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_halted"},      32'(halted), 0);
    chk({tag, "_fetch_err"},   32'(fetch_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; run = 1'b0; halt_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk); #1;
    run = 1'b1;
    t0  = cyc;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_events_left"}, 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; t0 = 0;
    rst = 1'b1; run = 1'b0; halt_req = 1'b0;
    en_valid = 1'b1; dly = 0;
    for (int i = 0; i < 256; i++) rom[i] = 6'h20;
    #12;
    chk_reset_outputs("rst_init");
    @(negedge clk); #1;
    rst = 1'b0;

    // Three-word program: ALU, store, halt
    rom[0] = 6'h04; rom[1] = 6'h1D; rom[2] = 6'h3C;
    ex(K_DEC, 'h04, -1, 2); ex(K_ALU, 0, -1, 3);
    ex(K_DEC, 'h1D, -1, 5); ex(K_STORE, 1, -1, 6);
    ex(K_DEC, 'h3C, -1, 8); ex(K_HALT, 2, 0, 9);
    start_run();
    drain("prog3", 40);
    chk("prog3_halted", 32'(halted), 1);
    chk("prog3_busy_in_halt", 32'(busy), 0);
    ex(K_IDLE, 2, -1, -1);
    run = 1'b0;
    drain("prog3_idle", 10);

    // Acknowledge delayed by five cycles
    do_reset();
    rom[0] = 6'h00; rom[1] = 6'h3C; dly = 5;
    ex(K_DEC, 'h00, -1, 7);  ex(K_ALU, 0, -1, 8);
    ex(K_DEC, 'h3C, -1, 15); ex(K_HALT, 1, 0, 16);
    start_run();
    drain("delay5", 60);
    chk("delay5_fetch_err", 32'(fetch_err), 0);
    ex(K_IDLE, 1, -1, -1);
    run = 1'b0;
    drain("delay5_idle", 10);

    // No acknowledge ever: timeout halts with sticky error
    do_reset();
    en_valid = 1'b0; dly = 0;
    ex(K_HALT, 0, 1, 16);
    start_run();
    drain("timeout", 40);
    chk("timeout_fetch_err", 32'(fetch_err), 1);
    chk("timeout_pc", 32'(prog_addr), 0);
    ex(K_IDLE, 0, -1, -1);
    run = 1'b0;
    drain("timeout_idle", 10);
    chk("timeout_err_sticky", 32'(fetch_err), 1);
    chk("timeout_halted_clear", 32'(halted), 0);

    // PC wraps from 0xFF to 0x00 on a NOP
    do_reset();
    en_valid = 1'b1; dly = 0;
    for (int i = 0; i < 256; i++) rom[i] = 6'h20;
    for (int i = 0; i < 256; i++) ex(K_DEC, 'h20, -1, 3 * i + 2);
    ex(K_DEC, 'h3C, -1, 770); ex(K_HALT, 0, 0, 771);
    start_run();
    begin
      int n = 0;
      while (prog_addr != 8'd1 && n < 20) begin @(negedge clk); #1; n++; end
      chk("wrap_reached_pc1", 32'(prog_addr), 1);
    end
    rom[0] = 6'h3C;
    drain("wrap", 900);
    chk("wrap_pc_after", 32'(prog_addr), 0);

    // halt_req during FETCH lets the instruction finish, then idles
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 6'h20;
    rom[0] = 6'h1D; dly = 3;
    ex(K_DEC, 'h1D, -1, 5); ex(K_STORE, 0, -1, 6); ex(K_IDLE, 1, -1, 7);
    start_run();
    begin
      int n = 0;
      while (!prog_rd && n < 10) begin @(negedge clk); #1; n++; end
      chk("hreq_in_fetch", 32'(prog_rd), 1);
    end
    halt_req = 1'b1;
    drain("hreq", 30);
    repeat (3) @(negedge clk);
    #1;
    chk("hreq_busy", 32'(busy), 0);
    chk("hreq_pc", 32'(prog_addr), 1);
    chk("hreq_stays_idle", 32'(prog_rd), 0);
    halt_req = 1'b0; run = 1'b0;

    // Asynchronous reset in DECODE: outputs clear without a clock edge
    do_reset();
    rom[0] = 6'h04; dly = 0;
    ex(K_DEC, 'h04, -1, 2);
    start_run();
    begin
      int n = 0;
      while (!ir_valid && n < 10) begin @(negedge clk); #1; n++; end
      chk("arst_in_decode", 32'(ir_valid), 1);
    end
    #1;
    rst = 1'b1; run = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("arst_no_strobe", 32'(sb.size()), 0);
    chk("arst_still_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
